// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with little-endian byte-lane
// writes, a fixed number of wait states per OKAY transfer and a two-cycle
// ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_lite_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic        hmaster,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int          ADDR_W     = IDX_W + 2;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;
    // Loading WAIT_STATES-1 and leaving at zero gives exactly WAIT_STATES
    // cycles in WAIT.
    localparam logic [2:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [2:0]        wait_cnt_reg;
    logic [2:0]        wait_cnt_next;

    // Latched address-phase information for the transfer in its data phase.
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        size_reg;
    logic              write_reg;
    logic              err_reg;

    logic [31:0]       mem_array [MEM_DEPTH];

    logic              accept_window;
    logic              accept;
    logic              illegal;
    logic [IDX_W-1:0]  word_idx;
    logic [3:0]        lane_en;
    logic              wr_en;

    // The bus protocol fields below carry no meaning for a plain memory.
    logic              unused_inputs;
    assign unused_inputs = ^{hburst, hmastlock, hmaster};

    // A new address phase can only land in a cycle where this slave drives
    // hreadyout=1 (IDLE, final DATA cycle, second ERROR cycle).
    assign accept_window = (state_reg == ST_IDLE) || (state_reg == ST_DATA) ||
                           (state_reg == ST_ERR2);
    assign accept        = accept_window && hsel && hready && htrans[1];

    // Decode of transfers that must be answered with ERROR.
    always_comb begin
        illegal = 1'b0;
        if ({1'b0, haddr} >= ADDR_LIMIT) begin
            illegal = 1'b1;
        end
        if (hsize > 3'd2) begin
            illegal = 1'b1;
        end
        if ((hsize == 3'd1) && haddr[0]) begin
            illegal = 1'b1;
        end
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
    end

    assign word_idx = addr_reg[ADDR_W-1:2];

    // Per-lane write enables from the latched size and low address bits.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_en[gi] = (size_reg == 3'd0) ? (addr_reg[1:0] == LANE) :
                             (size_reg == 3'd1) ? (addr_reg[1] == LANE[1]) :
                             (size_reg == 3'd2);
    end

    // The write commits on the edge that closes DATA; a reset forces IDLE
    // so a pending write can never reach the array.
    assign wr_en = (state_reg == ST_DATA) && write_reg && !err_reg;

    // State register and wait counter.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Address-phase capture on every accepted transfer.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_reg  <= '0;
            size_reg  <= 3'd0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            addr_reg  <= haddr[ADDR_W-1:0];
            size_reg  <= hsize;
            write_reg <= hwrite;
            err_reg   <= illegal;
        end
    end

    // Byte-lane memory write; memory contents are deliberately not reset.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem_array[word_idx][b*8 +: 8] <= hwdata[b*8 +: 8];
                end
            end
        end
    end

    // Next-state logic and bus responses.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        hreadyout     = 1'b1;
        hresp         = 1'b0;
        hrdata        = 32'h0;
        case (state_reg)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (wait_cnt_reg == 3'd0) begin
                    state_next = ST_DATA;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 3'd1;
                end
            end
            ST_ERR1: begin
                hreadyout  = 1'b0;
                hresp      = 1'b1;
                state_next = ST_ERR2;
            end
            default: begin
                if (state_reg == ST_ERR2) begin
                    hresp = 1'b1;
                end
                // Read data is combinational so a read that directly follows
                // a write sees the freshly committed word.
                if ((state_reg == ST_DATA) && !write_reg && !err_reg) begin
                    hrdata = mem_array[word_idx];
                end
                if (accept) begin
                    if (illegal) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

endmodule
